spatz_boot_sequencer: RTL and testbench
=======================================

Name: spatz_boot_sequencer

Overview:
- Hardware replacement for the simulation-only boot flow of the Spatz cluster.
- On a start request it waits a programmable delay, then writes the entry point into the cluster peripheral CLUSTER_BOOT_CONTROL register through a reqrsp master port.
- After the write response arrives it pulses debug_req to wake all cores.
- Sits between a host/SoC control source and the cluster wrapper's AXI-in path; its reqrsp port drives a reqrsp_to_axi converter.

Parameters:
- AddrWidth, 48, reqrsp address width (matches axi_addr_t).
- NumCores, 9, width of debug_req_o.
- BootAddr, 48'h0, full address of CLUSTER_BOOT_CONTROL (PeriStartAddr + offset).
- BootDelay, 1000, cycles between start acceptance and issuing the write; 0 means no delay.
- WakeCycles, 1, cycles debug_req_o is held high; must be >= 1.
- TimeoutCycles, 4096, response timeout; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  start request pulse/level, sampled only in IDLE and DONE
- entry_point_i  in  32  boot entry point, latched when start is accepted
- q_addr_o  out  AddrWidth  request address
- q_data_o  out  64  request write data
- q_write_o  out  1  request is a write
- q_strb_o  out  8  byte strobes
- q_valid_o  out  1  request valid
- q_ready_i  in  1  request ready
- p_valid_i  in  1  response valid
- p_error_i  in  1  response error flag
- p_ready_o  out  1  response ready
- debug_req_o  out  NumCores  core wake-up (debug request)
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence completed (sticky until next start)
- error_o  out  1  sequence failed (sticky until next start)

Behaviour:
- States: IDLE, DELAY, REQ, RSP, WAKE, DONE.
- Reset (asynchronous, any state): state=IDLE, counter=0, entry latch=0. All outputs 0 after reset, including q_valid_o, p_ready_o, debug_req_o, busy_o, done_o and error_o.
- A reset asserted mid-transaction drops q_valid_o immediately. No response is awaited afterwards.
- IDLE or DONE with start_i=1:
  - Latch entry_point_i.
  - Clear done_o and error_o.
  - Go to DELAY, or directly to REQ if BootDelay==0.
- DELAY:
  - Counter increments from 0 each cycle.
  - At BootDelay-1, go to REQ.
  - q_valid_o first rises exactly BootDelay+1 cycles after the start-accept edge.
  - start_i is ignored here.
- REQ:
  - q_valid_o=1, q_write_o=1, q_strb_o=8'hFF, q_addr_o=BootAddr, q_data_o={32'h0, latched entry}.
  - Payload is stable while q_valid_o && !q_ready_i.
  - On q_valid_o && q_ready_i, go to RSP next cycle.
  - q_valid_o never deasserts before the handshake.
- RSP:
  - p_ready_o=1. p_ready_o is 0 in every other state, so a response in REQ stalls upstream.
  - On p_valid_i && !p_error_i, go to WAKE.
  - On p_valid_i && p_error_i, set error_o and go to DONE without waking cores.
- WAKE:
  - debug_req_o='1 for exactly WakeCycles cycles (counter reused), then go to DONE.
- DONE: done_o=1; error_o holds its value.
- busy_o=1 in DELAY, REQ, RSP and WAKE; 0 in IDLE and DONE.
- Counter width is $clog2(max(BootDelay, WakeCycles, TimeoutCycles)+1); no wrap-around is possible within a state.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to q_valid_o or debug_req_o.

Optional Feature:
- Macro: SPATZ_BOOT_SEQ_TIMEOUT_EN.
- Defined:
  - In RSP, the counter counts cycles without p_valid_i.
  - After TimeoutCycles cycles, set error_o, go to DONE, deassert p_ready_o and do not wake cores.
  - A response arriving in the same cycle as the timeout wins (handled normally).
- Undefined: RSP waits indefinitely; TimeoutCycles is unused.

Test Plan:
- Reset, then hold rst_i=0 and start_i=0 for 50 cycles -> all outputs 0, state IDLE.
- BootDelay=10, entry_point_i=32'h8000_0000, start pulse, q_ready_i=1, response after 3 cycles with p_error_i=0 -> q_valid_o rises 11 cycles after start with q_data_o=64'h0000_0000_8000_0000 and q_addr_o=BootAddr; debug_req_o='1 for 1 cycle; then done_o=1, busy_o=0.
- q_ready_i held 0 for 20 cycles in REQ -> q_valid_o stays 1 and payload is unchanged every cycle; single handshake on the first cycle q_ready_i=1.
- Response with p_error_i=1 -> error_o=1, done_o=1, debug_req_o never asserted. A new start clears both flags and the sequence reruns.
- rst_i asserted in REQ and in WAKE -> q_valid_o and debug_req_o drop to 0 asynchronously; after release, state is IDLE.
- With SPATZ_BOOT_SEQ_TIMEOUT_EN and TimeoutCycles=16, no response -> error_o=1 at RSP entry +16 cycles, no wake. Response at cycle 16 -> normal wake.

Source files
------------

// File: rtl/spatz_boot_sequencer.sv
// -----------------------------------------------------------------------------
// spatz_boot_sequencer
//
// Hardware boot flow for the Spatz cluster. On an accepted start request the
// block waits BootDelay cycles. It then writes the latched entry point into
// CLUSTER_BOOT_CONTROL through a reqrsp master port. When the write response
// returns without error, it pulses debug_req_o to wake every core.
//
// Optional feature (compile-time macro):
//   SPATZ_BOOT_SEQ_TIMEOUT_EN - abort the response wait after TimeoutCycles
//                               cycles, flag error_o and skip the wake-up.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             start request, sampled only in IDLE and DONE
//   entry_point_i       boot entry point, latched when start is accepted
//   q_*                 reqrsp request channel (single 64-bit write)
//   p_valid_i/p_error_i reqrsp response channel, p_ready_o accepts it
//   debug_req_o         per-core wake-up request
//   busy_o              sequence in progress
//   done_o, error_o     sticky completion / failure flags, cleared on start
// -----------------------------------------------------------------------------
module spatz_boot_sequencer #(
   parameter int unsigned          AddrWidth     = 48,
   parameter int unsigned          NumCores      = 9,
   parameter logic [AddrWidth-1:0] BootAddr      = '0,
   parameter int unsigned          BootDelay     = 1000,
   parameter int unsigned          WakeCycles    = 1,    // must be >= 1
   parameter int unsigned          TimeoutCycles = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [31:0]          entry_point_i,
   output logic [AddrWidth-1:0] q_addr_o,
   output logic [63:0]          q_data_o,
   output logic                 q_write_o,
   output logic [7:0]           q_strb_o,
   output logic                 q_valid_o,
   input  logic                 q_ready_i,
   input  logic                 p_valid_i,
   input  logic                 p_error_i,
   output logic                 p_ready_o,
   output logic [NumCores-1:0]  debug_req_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      REQ,
      RSP,
      WAKE,
      DONE
   } state_e;

   // One counter serves the delay, the wake pulse and the response timeout,
   // so it is sized for the largest of the three.
   localparam int unsigned CntMax0 = (BootDelay > WakeCycles) ? BootDelay : WakeCycles;
   localparam int unsigned CntMax  = (CntMax0 > TimeoutCycles) ? CntMax0 : TimeoutCycles;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   // Terminal counts. DelayLast is meaningless when BootDelay==0 because
   // DELAY is then never entered.
   localparam logic [CntW-1:0] DelayLast = CntW'(BootDelay - 1);
   localparam logic [CntW-1:0] WakeLast  = CntW'(WakeCycles - 1);
`ifdef SPATZ_BOOT_SEQ_TIMEOUT_EN
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
`endif

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [31:0]     entry_q;
   logic            q_valid_q;
   logic            error_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the entry latch is a plain register, not a memory, so it is
         // reset with everything else and the outputs are clean from reset.
         state_q   <= IDLE;
         cnt_q     <= '0;
         entry_q   <= '0;
         q_valid_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  entry_q <= entry_point_i;
                  error_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= (BootDelay == 0) ? REQ : DELAY;
               end
            end

            DELAY: begin
               if (cnt_q == DelayLast) begin
                  state_q <= REQ;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // The first REQ cycle only raises the registered valid. That keeps
            // q_valid_o free of input paths and places its rising edge
            // BootDelay+1 cycles after the start is accepted.
            REQ: begin
               if (!q_valid_q) begin
                  q_valid_q <= 1'b1;
               end else if (q_ready_i) begin
                  q_valid_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= RSP;
               end
            end

            // A response is checked before the timeout, so a response that
            // arrives in the final cycle is handled normally.
            RSP: begin
               if (p_valid_i) begin
                  if (p_error_i) begin
                     error_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= WAKE;
                  end
               end
`ifdef SPATZ_BOOT_SEQ_TIMEOUT_EN
               else if (cnt_q == TimeoutLast) begin
                  error_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end

            WAKE: begin
               if (cnt_q == WakeLast) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   // The payload is qualified by valid, so the bus is quiet outside the
   // request. It is stable during a stall because entry_q changes only in
   // IDLE and DONE.
   assign q_valid_o = q_valid_q;
   assign q_write_o = q_valid_q;
   assign q_strb_o  = {8{q_valid_q}};
   assign q_addr_o  = q_valid_q ? BootAddr : '0;
   assign q_data_o  = q_valid_q ? {32'h0, entry_q} : 64'h0;

   // These are decoded from state only. The reset therefore clears them
   // immediately, and a response arriving outside RSP is held off upstream.
   assign p_ready_o   = (state_q == RSP);
   assign debug_req_o = {NumCores{state_q == WAKE}};
   assign busy_o      = (state_q == DELAY) || (state_q == REQ) ||
                        (state_q == RSP)   || (state_q == WAKE);
   assign done_o      = (state_q == DONE);
   assign error_o     = error_q;

endmodule

// File: tb/tb_spatz_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spatz_boot_sequencer
//
// Directed bench for spatz_boot_sequencer. Two instances share the clock and
// the reset:
//   u_dut_a  BootDelay=10, WakeCycles=1, TimeoutCycles=16
//   u_dut_b  BootDelay=0,  WakeCycles=3, TimeoutCycles=16
// The main boot flow is driven from a vector table. The stall, error, restart,
// reset and timeout corners are driven as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_spatz_boot_sequencer;

   localparam int unsigned    ADDR_W    = 48;
   localparam int unsigned    NCORES    = 9;
   localparam logic [47:0]    BOOT_ADDR = 48'h0000_5100_0058;
`ifdef SPATZ_BOOT_SEQ_TIMEOUT_EN
   localparam int             RSP_WAIT  = 5;
`else
   localparam int             RSP_WAIT  = 20;
`endif

   logic clk_i = 1'b0;
   logic rst_i;

   // Instance A signals
   logic              start_i, q_ready_i, p_valid_i, p_error_i;
   logic [31:0]       entry_point_i;
   logic [ADDR_W-1:0] q_addr_o;
   logic [63:0]       q_data_o;
   logic              q_write_o, q_valid_o, p_ready_o, busy_o, done_o, error_o;
   logic [7:0]        q_strb_o;
   logic [NCORES-1:0] debug_req_o;

   // Instance B signals
   logic              start_b, q_ready_b, p_valid_b, p_error_b;
   logic [31:0]       entry_b;
   logic [ADDR_W-1:0] q_addr_b;
   logic [63:0]       q_data_b;
   logic              q_write_b, q_valid_b, p_ready_b, busy_b, done_b, error_b;
   logic [7:0]        q_strb_b;
   logic [NCORES-1:0] debug_req_b;

   int checks   = 0;
   int failures = 0;

   spatz_boot_sequencer #(
      .AddrWidth(ADDR_W), .NumCores(NCORES), .BootAddr(BOOT_ADDR),
      .BootDelay(10), .WakeCycles(1), .TimeoutCycles(16)
   ) u_dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .entry_point_i(entry_point_i),
      .q_addr_o(q_addr_o), .q_data_o(q_data_o), .q_write_o(q_write_o), .q_strb_o(q_strb_o),
      .q_valid_o(q_valid_o), .q_ready_i(q_ready_i), .p_valid_i(p_valid_i),
      .p_error_i(p_error_i), .p_ready_o(p_ready_o), .debug_req_o(debug_req_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   spatz_boot_sequencer #(
      .AddrWidth(ADDR_W), .NumCores(NCORES), .BootAddr(BOOT_ADDR),
      .BootDelay(0), .WakeCycles(3), .TimeoutCycles(16)
   ) u_dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_b), .entry_point_i(entry_b),
      .q_addr_o(q_addr_b), .q_data_o(q_data_b), .q_write_o(q_write_b), .q_strb_o(q_strb_b),
      .q_valid_o(q_valid_b), .q_ready_i(q_ready_b), .p_valid_i(p_valid_b),
      .p_error_i(p_error_b), .p_ready_o(p_ready_b), .debug_req_o(debug_req_b),
      .busy_o(busy_b), .done_o(done_b), .error_o(error_b)
   );

   always #5 clk_i = ~clk_i;

   // Vector record: in = {start, q_ready, p_valid, p_error},
   //                exp = {q_valid, p_ready, busy, done, error, debug_all}
   typedef struct packed {
      logic [3:0] in;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [13:0] expv(input logic [5:0] e);
      return {e[5:1], {NCORES{e[0]}}};
   endfunction

   function automatic logic [13:0] obs_a();
      return {q_valid_o, p_ready_o, busy_o, done_o, error_o, debug_req_o};
   endfunction

   function automatic logic [13:0] obs_b();
      return {q_valid_b, p_ready_b, busy_b, done_b, error_b, debug_req_b};
   endfunction

   task automatic check_payload(input string name, input logic [31:0] entry);
      check(name, {q_write_o, q_strb_o, q_addr_o, q_data_o},
            {1'b1, 8'hFF, BOOT_ADDR, 32'h0, entry});
   endtask

   task automatic wait_qv_a(input string name, input int budget);
      int n = 0;
      while (!q_valid_o && n < budget) begin
         step();
         n++;
      end
      check(name, q_valid_o, 1'b1);
   endtask

   task automatic push(input logic [3:0] in, input logic [5:0] exp);
      vec_t v;
      v.in  = in;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic start_a(input logic [31:0] entry);
      entry_point_i = entry;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "watchdog");
   end

   initial begin
      // Main boot flow: start in cycle 0, q_valid rises after the 11th edge,
      // 3-cycle response, 1-cycle wake, then DONE. start is held high during
      // the first DELAY cycles to show that DELAY ignores it.
      push(4'b1000, 6'b001000);
      push(4'b1000, 6'b001000);
      push(4'b1000, 6'b001000);
      for (int i = 3; i <= 10; i++) push(4'b0000, 6'b001000);
      push(4'b0100, 6'b101000);   // REQ issue cycle: valid rises
      push(4'b0100, 6'b011000);   // handshake -> RSP
      push(4'b0000, 6'b011000);
      push(4'b0000, 6'b011000);
      push(4'b0010, 6'b001001);   // good response -> WAKE
      push(4'b0000, 6'b000100);   // DONE
      push(4'b0000, 6'b000100);

      rst_i = 1'b1;
      start_i = 1'b0; q_ready_i = 1'b0; p_valid_i = 1'b0; p_error_i = 1'b0;
      entry_point_i = 32'h0;
      start_b = 1'b0; q_ready_b = 1'b0; p_valid_b = 1'b0; p_error_b = 1'b0;
      entry_b = 32'h0;
      #2;
      check("reset_a", {obs_a(), q_write_o, q_strb_o, q_addr_o, q_data_o}, '0);
      check("reset_b", obs_b(), '0);
      #20 rst_i = 1'b0;

      // Quiet idle period
      for (int i = 0; i < 50; i++) begin
         step();
         check($sformatf("idle_a%0d", i), {obs_a(), q_write_o, q_strb_o, q_addr_o, q_data_o}, '0);
         check($sformatf("idle_b%0d", i), obs_b(), '0);
      end

      // Table-driven main flow
      entry_point_i = 32'h8000_0000;
      for (int i = 0; i < vecs.size(); i++) begin
         {start_i, q_ready_i, p_valid_i, p_error_i} = vecs[i].in;
         step();
         check($sformatf("vec%0d", i), obs_a(), expv(vecs[i].exp));
         if (vecs[i].exp[5]) check_payload($sformatf("vec%0d_payload", i), 32'h8000_0000);
      end
      {start_i, q_ready_i, p_valid_i, p_error_i} = 4'b0000;

      // Stalled request: the payload holds for 20 cycles, and a change on
      // entry_point_i after acceptance must not leak through.
      start_a(32'h1234_5678);
      check("stall_accept", obs_a(), expv(6'b001000));
      entry_point_i = 32'hDEAD_BEEF;
      wait_qv_a("stall_rise", 20);
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("stall_hold%0d", i), obs_a(), expv(6'b101000));
         check_payload($sformatf("stall_payload%0d", i), 32'h1234_5678);
      end
      q_ready_i = 1'b1;
      step();
      q_ready_i = 1'b0;
      check("stall_handshake", obs_a(), expv(6'b011000));
      for (int i = 0; i < RSP_WAIT; i++) begin
         step();
         check($sformatf("rsp_wait%0d", i), obs_a(), expv(6'b011000));
      end

      // Error response: no wake, both flags sticky
      p_valid_i = 1'b1; p_error_i = 1'b1;
      step();
      p_valid_i = 1'b0; p_error_i = 1'b0;
      check("err_done", obs_a(), expv(6'b000110));
      step();
      check("err_sticky", obs_a(), expv(6'b000110));

      // Restart clears the flags and reruns the sequence
      start_a(32'hA5A5_0001);
      check("restart_clear", obs_a(), expv(6'b001000));
      q_ready_i = 1'b1;
      wait_qv_a("restart_req", 20);
      check_payload("restart_payload", 32'hA5A5_0001);
      step();
      q_ready_i = 1'b0;
      check("restart_rsp", obs_a(), expv(6'b011000));
      p_valid_i = 1'b1;
      step();
      p_valid_i = 1'b0;
      check("restart_wake", obs_a(), expv(6'b001001));
      step();
      check("restart_done", obs_a(), expv(6'b000100));

      // Reset asserted in REQ drops valid between clock edges
      start_a(32'h0000_1111);
      wait_qv_a("rst_req_pre", 20);
      #3 rst_i = 1'b1;
      #1;
      check("rst_req_async", {obs_a(), q_write_o, q_strb_o, q_addr_o, q_data_o}, '0);
      step();
      #2 rst_i = 1'b0;
      step();
      check("rst_req_idle", obs_a(), '0);

      // Reset asserted in WAKE drops debug_req between clock edges
      start_a(32'h0000_2222);
      q_ready_i = 1'b1;
      wait_qv_a("rst_wake_req", 20);
      step();
      q_ready_i = 1'b0;
      p_valid_i = 1'b1;
      step();
      p_valid_i = 1'b0;
      check("rst_wake_pre", obs_a(), expv(6'b001001));
      #3 rst_i = 1'b1;
      #1;
      check("rst_wake_async", obs_a(), '0);
      step();
      #2 rst_i = 1'b0;
      step();
      check("rst_wake_idle", obs_a(), '0);

`ifdef SPATZ_BOOT_SEQ_TIMEOUT_EN
      // No response: timeout 16 cycles after RSP entry, no wake
      start_a(32'h0000_3333);
      q_ready_i = 1'b1;
      wait_qv_a("to_req", 20);
      step();
      q_ready_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         check($sformatf("to_wait%0d", i), obs_a(), expv(6'b011000));
      end
      step();
      check("timeout", obs_a(), expv(6'b000110));

      // A response in the final cycle is handled as a normal response
      start_a(32'h0000_4444);
      q_ready_i = 1'b1;
      wait_qv_a("late_req", 20);
      step();
      q_ready_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         check($sformatf("late_wait%0d", i), obs_a(), expv(6'b011000));
      end
      p_valid_i = 1'b1;
      step();
      p_valid_i = 1'b0;
      check("late_rsp_wake", obs_a(), expv(6'b001001));
      step();
      check("late_rsp_done", obs_a(), expv(6'b000100));
`endif

      // Instance B: zero delay, so valid rises one cycle after acceptance,
      // followed by a 3-cycle wake pulse.
      entry_b = 32'h0000_4000;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      check("b_accept", obs_b(), expv(6'b001000));
      step();
      check("b_valid", obs_b(), expv(6'b101000));
      check("b_payload", {q_write_b, q_strb_b, q_addr_b, q_data_b},
            {1'b1, 8'hFF, BOOT_ADDR, 32'h0, 32'h0000_4000});
      q_ready_b = 1'b1;
      step();
      q_ready_b = 1'b0;
      check("b_rsp", obs_b(), expv(6'b011000));
      p_valid_b = 1'b1;
      step();
      p_valid_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b_wake%0d", i), obs_b(), expv(6'b001001));
         step();
      end
      check("b_done", obs_b(), expv(6'b000100));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
